wb_arbiter: RTL

//   Write-side master of the register file: merges single-cycle ALU results and

---
 rtl/wb_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter for the register file write port.
// ALU results win with fixed priority. Load responses go through a small FIFO,
// or bypass it straight to the write port when nothing else is waiting.
// ld_pending_mask tells the hazard unit which registers still have a
// buffered load in flight.
// Optional build macro: WB_STATS_EN adds the ld_stall_cnt output.
//
// Load handshake (valid/ready):
//   - A response transfers on a cycle where ld_valid && ld_ready.
//   - ld_ready = !full. It ignores ld_valid and ignores a pop in the same
//     cycle, so a full FIFO never passes a response through.
//   - The producer holds ld_rd/ld_data stable while ld_valid && !ld_ready.
module wb_arbiter #(
    parameter int LD_FIFO_DEPTH = 4,
    parameter int XLEN          = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            reg_write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_wdata,
`ifdef WB_STATS_EN
    output logic [31:0]     ld_stall_cnt,
`endif
    output logic [31:0]     ld_pending_mask
);

    localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;

    // FIFO storage and bookkeeping. One valid bit per slot makes the pending
    // mask a plain OR over occupied slots.
    logic [4:0]               fifo_rd_q   [LD_FIFO_DEPTH];
    logic [XLEN-1:0]          fifo_data_q [LD_FIFO_DEPTH];
    logic [LD_FIFO_DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;

    // Registered write-port outputs.
    logic                     reg_write_q, reg_write_d;
    logic [4:0]               rd_q, rd_d;
    logic [XLEN-1:0]          rd_wdata_q, rd_wdata_d;

    // Arbitration decode.
    logic fifo_empty;
    logic fifo_full;
    logic alu_req;
    logic ld_fire;
    logic ld_live;
    logic do_pop;
    logic do_bypass;
    logic do_push;

    assign fifo_empty = ~|valid_q;
    assign fifo_full  = &valid_q;

    // Ready is held low during reset and depends only on FIFO occupancy.
    assign ld_ready   = reset_n & ~fifo_full;

    // A write to x0 is no request at all. A load to x0 still handshakes but
    // is dropped here.
    assign alu_req    = alu_valid & (alu_rd != 5'd0);
    assign ld_fire    = ld_valid & ld_ready;
    assign ld_live    = ld_fire & (ld_rd != 5'd0);

    // Priority: ALU, then FIFO head, then the incoming load as a bypass.
    assign do_pop     = ~alu_req & ~fifo_empty;
    assign do_bypass  = ~alu_req & fifo_empty & ld_live;
    assign do_push    = ld_live & ~do_bypass;

    // Next-state for FIFO pointers and occupancy. A push and a pop can land
    // on the same cycle, but never on the same slot: push needs !full.
    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
    end

    // Write-port selection. When nothing writes, rd/rd_wdata hold their value.
    always_comb begin
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        rd_wdata_d  = rd_wdata_q;
        if (alu_req) begin
            reg_write_d = 1'b1;
            rd_d        = alu_rd;
            rd_wdata_d  = alu_data;
        end else if (do_pop) begin
            reg_write_d = 1'b1;
            rd_d        = fifo_rd_q[rd_ptr_q];
            rd_wdata_d  = fifo_data_q[rd_ptr_q];
        end else if (do_bypass) begin
            reg_write_d = 1'b1;
            rd_d        = ld_rd;
            rd_wdata_d  = ld_data;
        end
    end

    // Control state: occupancy, pointers and the registered write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            rd_wdata_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            rd_wdata_q  <= rd_wdata_d;
        end
    end

    // FIFO payload storage. Slots only mean something while their valid
    // bit is set, so this storage needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_rd_q[wr_ptr_q]   <= ld_rd;
            fifo_data_q[wr_ptr_q] <= ld_data;
        end
    end

    // Pending-destination mask: one-hot of rd for every occupied slot.
    always_comb begin
        ld_pending_mask = '0;
        for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
            if (valid_q[i]) begin
                ld_pending_mask[fifo_rd_q[i]] = 1'b1;
            end
        end
    end

    assign reg_write = reg_write_q;
    assign rd        = rd_q;
    assign rd_wdata  = rd_wdata_q;

`ifdef WB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a buffered load waits behind an ALU write.
    // The counter wraps.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (alu_req && !fifo_empty) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ld_stall_cnt = stall_cnt_q;
`endif

endmodule
